calc_keypad_encoder: RTL and testbench

Front-end for the fixed-point calculator. It takes 16 raw, asynchronous, active-high physical keys (digits 0–9, four operators, equal, clear), synchronises and debounces them, and emits exactly one single-cycle 10-bit button code per key press. The output drives the `button` input of `math_calculator_fsm` directly. It produces the same code-then-zero pattern the calculator FSM consumes.

---
 rtl/calc_pkg.sv | 72 +++++++
 rtl/sync_2ff.sv | 23 ++
 rtl/calc_keypad_encoder.sv | 98 +++++++++
 tb/tb_calc_keypad_encoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the fixed-point calculator: button codes, key indices,
// key-to-button mapping and the keypad encoder state type.
package calc_pkg;

  localparam logic [9:0] BTN_ZERO  = 10'b00_0000_0001;
  localparam logic [9:0] BTN_ONE   = 10'b00_0000_0010;
  localparam logic [9:0] BTN_TWO   = 10'b00_0000_0100;
  localparam logic [9:0] BTN_THREE = 10'b00_0000_1000;
  localparam logic [9:0] BTN_FOUR  = 10'b00_0001_0000;
  localparam logic [9:0] BTN_FIVE  = 10'b00_0010_0000;
  localparam logic [9:0] BTN_SIX   = 10'b00_0100_0000;
  localparam logic [9:0] BTN_SEVEN = 10'b00_1000_0000;
  localparam logic [9:0] BTN_EIGHT = 10'b01_0000_0000;
  localparam logic [9:0] BTN_NINE  = 10'b01_0000_0001;
  localparam logic [9:0] BTN_ADD   = 10'b10_0000_0001;
  localparam logic [9:0] BTN_SUB   = 10'b10_0000_0010;
  localparam logic [9:0] BTN_MUL   = 10'b10_0000_0100;
  localparam logic [9:0] BTN_DIV   = 10'b10_0000_1000;
  localparam logic [9:0] BTN_EQUAL = 10'b11_0000_0000;
  localparam logic [9:0] BTN_CLEAR = 10'b11_1000_0000;

  localparam logic [3:0] KEY_ZERO  = 4'd0;
  localparam logic [3:0] KEY_ONE   = 4'd1;
  localparam logic [3:0] KEY_TWO   = 4'd2;
  localparam logic [3:0] KEY_THREE = 4'd3;
  localparam logic [3:0] KEY_FOUR  = 4'd4;
  localparam logic [3:0] KEY_FIVE  = 4'd5;
  localparam logic [3:0] KEY_SIX   = 4'd6;
  localparam logic [3:0] KEY_SEVEN = 4'd7;
  localparam logic [3:0] KEY_EIGHT = 4'd8;
  localparam logic [3:0] KEY_NINE  = 4'd9;
  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_DIV   = 4'd13;
  localparam logic [3:0] KEY_EQUAL = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StPressDb,
    StEmit,
    StHold,
    StRelDb
  } key_state_e;

  function automatic logic [9:0] key_to_button(input logic [3:0] idx);
    logic [9:0] code;
    code = 10'd0;
    case (idx)
      KEY_ZERO:  code = BTN_ZERO;
      KEY_ONE:   code = BTN_ONE;
      KEY_TWO:   code = BTN_TWO;
      KEY_THREE: code = BTN_THREE;
      KEY_FOUR:  code = BTN_FOUR;
      KEY_FIVE:  code = BTN_FIVE;
      KEY_SIX:   code = BTN_SIX;
      KEY_SEVEN: code = BTN_SEVEN;
      KEY_EIGHT: code = BTN_EIGHT;
      KEY_NINE:  code = BTN_NINE;
      KEY_ADD:   code = BTN_ADD;
      KEY_SUB:   code = BTN_SUB;
      KEY_MUL:   code = BTN_MUL;
      KEY_DIV:   code = BTN_DIV;
      KEY_EQUAL: code = BTN_EQUAL;
      KEY_CLEAR: code = BTN_CLEAR;
      default:   code = 10'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; both stages clear on rst.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/calc_keypad_encoder.sv
// Debounced single-key encoder: turns 16 raw keys into one-cycle calculator
// button codes, one per accepted press.
module calc_keypad_encoder
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_raw,
  output logic [9:0]  button,
  output logic        key_held
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [15:0]     key_sync;
  logic [3:0]      prio_idx;
  key_state_e      state_q;
  logic [3:0]      key_idx_q;
  logic [CntW-1:0] cnt_q;

  sync_2ff #(
    .WIDTH(16)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(key_raw),
    .q_o(key_sync)
  );

  // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    prio_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_sync[i]) prio_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      key_idx_q <= 4'd0;
      cnt_q     <= '0;
      button    <= 10'd0;
      key_held  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (key_sync != 16'd0) begin
            key_idx_q <= prio_idx;
            cnt_q     <= '0;
            state_q   <= StPressDb;
          end
        end
        StPressDb: begin
          // Only the latched key is tracked; a different key does not inherit the count.
          if (!key_sync[key_idx_q]) begin
            state_q <= StIdle;
          end else if (cnt_q == CntMax) begin
            button   <= key_to_button(key_idx_q);
            key_held <= 1'b1;
            state_q  <= StEmit;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEmit: begin
          button  <= 10'd0;
          state_q <= StHold;
        end
        StHold: begin
          if (key_sync == 16'd0) begin
            cnt_q   <= '0;
            state_q <= StRelDb;
          end
        end
        StRelDb: begin
          if (key_sync != 16'd0) begin
            state_q <= StHold;
          end else if (cnt_q == CntMax) begin
            key_held <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          button   <= 10'd0;
          key_held <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_keypad_encoder.sv
// Directed bench for calc_keypad_encoder with DEBOUNCE_CYCLES = 4.
module tb_calc_keypad_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_raw;
  logic [9:0]  button;
  logic        key_held;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int b2b        = 0;
  bit prev_nz    = 1'b0;

  logic [9:0] log_code[$];
  int         log_cyc[$];

  always #5 clk = ~clk;

  calc_keypad_encoder #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_raw(key_raw),
    .button(button),
    .key_held(key_held)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Emission log: every non-zero code with the index of the edge that produced it.
  always @(negedge clk) begin
    if (button != 10'd0) begin
      log_code.push_back(button);
      log_cyc.push_back(cyc);
      if (prev_nz) b2b++;
    end
    prev_nz = (button != 10'd0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int n, input logic [9:0] code, input int at);
    check({tag, "_count"}, log_code.size(), n);
    if (log_code.size() > 0) begin
      check({tag, "_code"}, log_code[0], code);
      check({tag, "_cycle"}, log_cyc[0], at);
    end
    log_code.delete();
    log_cyc.delete();
  endtask

  int         keys[14]      = '{5, 2, 5, 11, 7, 0, 5, 14, 13, 8, 0, 0, 14, 15};
  logic [9:0] exp_codes[14] = '{10'h020, 10'h004, 10'h020, 10'h202, 10'h080, 10'h001, 10'h020,
                                10'h300, 10'h208, 10'h100, 10'h001, 10'h001, 10'h300, 10'h380};
  int         starts[14];

  initial begin
    int s;
    int w;
    rst     = 1'b1;
    key_raw = 16'd0;
    tick(3);
    check("reset_button", button, 10'd0);
    check("reset_held", key_held, 1'b0);
    rst = 1'b0;
    tick(2);
    log_code.delete();
    log_cyc.delete();

    // 1: clean press of digit 5
    s = cyc;
    key_raw = 16'h0020;
    tick(6);
    check("s1_pre_emit", button, 10'd0);
    check("s1_held_low", key_held, 1'b0);
    tick(1);
    check("s1_emit", button, 10'h020);
    check("s1_held_rise", key_held, 1'b1);
    tick(1);
    check("s1_one_cycle", button, 10'd0);
    tick(12);
    key_raw = 16'd0;
    tick(6);
    check("s1_held_still", key_held, 1'b1);
    tick(1);
    check("s1_held_fall", key_held, 1'b0);
    tick(5);
    check_log("s1", 1, 10'h020, s + 7);

    // 2: 2-high/1-low bounce on digit 3, then stable
    s = cyc;
    key_raw = 16'h0008;
    tick(2);
    key_raw = 16'd0;
    tick(1);
    key_raw = 16'h0008;
    tick(6);
    check("s2_no_early", log_code.size(), 0);
    tick(14);
    key_raw = 16'd0;
    tick(12);
    check_log("s2", 1, 10'h008, s + 10);

    // 3: equal and digit 2 together; digit 2 released last
    s = cyc;
    key_raw = 16'h4004;
    tick(12);
    key_raw = 16'h0004;
    tick(12);
    check("s3_held_on_2", key_held, 1'b1);
    key_raw = 16'd0;
    tick(12);
    check_log("s3", 1, 10'h300, s + 7);

    // 4: calculator key sequence
    for (int i = 0; i < 14; i++) begin
      starts[i] = cyc;
      key_raw = 16'd0;
      key_raw[keys[i]] = 1'b1;
      tick(12);
      key_raw = 16'd0;
      tick(12);
    end
    check("s4_count", log_code.size(), 14);
    for (int i = 0; i < 14; i++) begin
      if (i < log_code.size()) begin
        check($sformatf("s4_code%0d", i), log_code[i], exp_codes[i]);
        check($sformatf("s4_cycle%0d", i), log_cyc[i], starts[i] + 7);
      end
    end
    log_code.delete();
    log_cyc.delete();

    // 5: reset lands on the EMIT edge; key stays held through reset
    key_raw = 16'h0200;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("s5_lost", button, 10'd0);
    check("s5_held_reset", key_held, 1'b0);
    tick(1);
    rst = 1'b0;
    w = cyc;
    tick(10);
    key_raw = 16'd0;
    tick(12);
    check_log("s5", 1, 10'h101, w + 7);

    // 6: 3-cycle release glitch on add while held
    s = cyc;
    key_raw = 16'h0400;
    tick(12);
    key_raw = 16'd0;
    tick(3);
    key_raw = 16'h0400;
    tick(10);
    check("s6_held", key_held, 1'b1);
    key_raw = 16'd0;
    tick(12);
    check_log("s6", 1, 10'h201, s + 7);

    check("no_back_to_back", b2b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
